// File: rtl/conv_pkg.sv
// Shared defaults, FSM state encoding and helpers for the result output path.
`timescale 1ns/1ps
package conv_pkg;

  localparam int unsigned DATA_W_DEF = 24;
  localparam int unsigned ADDR_W_DEF = 13;
  localparam int unsigned BYTE_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_SEND  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Width of a byte index able to address n bytes (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/data_out_controller.sv
// Stores a captured result word to memory, then streams it out LSB byte first.
`timescale 1ns/1ps
module data_out_controller
  import conv_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned BYTE_W = BYTE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] addr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int unsigned NBYTES = DATA_W / BYTE_W;
  localparam int unsigned IDX_W  = idx_width(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_e              state_q,     state_d;
  logic                start_q,     start_d;
  logic                arm_q,       arm_d;
  logic [IDX_W-1:0]    idx_q,       idx_d;
  logic [DATA_W-1:0]   word_q,      word_d;
  logic [ADDR_W-1:0]   waddr_q,     waddr_d;
  logic                mem_we_q,    mem_we_d;
  logic [BYTE_W-1:0]   out_data_q,  out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q,      busy_d;
  logic                done_q,      done_d;
  logic                trig_c;
  logic                accept_c;

  // A rising edge counts only once start has been seen low since reset,
  // so a level held high through reset release cannot fire a transfer.
  assign trig_c   = start & ~start_q & arm_q;
  assign accept_c = out_valid_q & out_ready;

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      start_q     <= 1'b0;
      arm_q       <= ~start;
      idx_q       <= '0;
      word_q      <= '0;
      waddr_q     <= '0;
      mem_we_q    <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      arm_q       <= arm_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
      waddr_q     <= waddr_d;
      mem_we_q    <= mem_we_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next state plus outputs decoded from the next state so they align with it.
  always_comb begin
    state_d     = state_q;
    start_d     = start;
    arm_d       = arm_q | ~start;
    idx_d       = idx_q;
    word_d      = word_q;
    waddr_d     = waddr_q;
    mem_we_d    = 1'b0;
    out_data_d  = '0;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (trig_c) begin
          word_d  = data;
          waddr_d = addr;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        idx_d   = '0;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (accept_c) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    mem_we_d    = (state_d == ST_WRITE);
    out_valid_d = (state_d == ST_SEND);
    done_d      = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);

    if (state_d == ST_SEND) begin
      for (int unsigned b = 0; b < NBYTES; b++) begin
        if (idx_d == IDX_W'(b)) begin
          out_data_d = word_d[b*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = waddr_q;
  assign mem_din   = word_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_data_out_controller.sv
// Self-checking bench for data_out_controller with a queue-based reference model.
`timescale 1ns/1ps

// Simulation-only free-running clock: starts low, 10 ns period.
module clock_gen (
  output logic clk
);
  initial clk = 1'b0;
  always #5 clk = ~clk;
endmodule

module tb_data_out_controller;

  localparam int unsigned DATA_W = 24;
  localparam int unsigned ADDR_W = 13;
  localparam int unsigned BYTE_W = 8;
  localparam int          NBYTES = 3;

  logic              clk;
  logic              rst;
  logic              start;
  logic [DATA_W-1:0] data;
  logic [ADDR_W-1:0] addr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [BYTE_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [DATA_W-1:0] wr_din_q[$];
  int                wr_cyc_q[$];
  logic [BYTE_W-1:0] byte_q[$];
  int                first_valid_cyc;
  int                done_cnt;
  int                done_cyc;
  int                stall_cycles;
  int                stall_viol;
  logic              prev_stall;
  logic [BYTE_W-1:0] prev_byte;
  bit                rand_ready;

  clock_gen u_clk (.clk(clk));

  data_out_controller #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .BYTE_W(BYTE_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .data     (data),
    .addr     (addr),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .done     (done)
  );

  // Cycle counter: value k means "the cycle after the k-th rising edge".
  always @(posedge clk) cyc = cyc + 1;

  // Random downstream back-pressure when enabled.
  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Mid-cycle observer: logs memory writes, accepted bytes and done pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) begin
        wr_addr_q.push_back(mem_addr);
        wr_din_q.push_back(mem_din);
        wr_cyc_q.push_back(cyc);
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (prev_stall && out_valid && out_data !== prev_byte) stall_viol++;
      if (out_valid && !out_ready) stall_cycles++;
      if (out_valid && out_ready) byte_q.push_back(out_data);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_byte  = out_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Reference: byte i of a word, least significant first.
  function automatic logic [BYTE_W-1:0] exp_byte(input logic [DATA_W-1:0] w, input int i);
    logic [DATA_W-1:0] s;
    s = w >> (i * BYTE_W);
    return s[BYTE_W-1:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_din_q.delete();
    wr_cyc_q.delete();
    byte_q.delete();
    first_valid_cyc = -1;
    done_cnt        = 0;
    done_cyc        = -1;
    stall_cycles    = 0;
    stall_viol      = 0;
  endtask

  // Wait for busy to rise and fall again, bounded.
  task automatic wait_xfer(output bit ok);
    int  n = 0;
    bit  seen = 0;
    while (!busy && n < 50) begin step(); n++; end
    seen = busy;
    while (busy && n < 400) begin step(); n++; end
    ok = seen && !busy;
  endtask

  // Single rising edge on start with the given word/address, then wait out the transfer.
  task automatic pulse_xfer(input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] a,
                            output int t0, output bit ok);
    data  = d;
    addr  = a;
    start = 1'b1;
    t0    = cyc;
    step();
    start = 1'b0;
    wait_xfer(ok);
    repeat (2) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; data = '0; addr = '0;
    repeat (2) step();
    n_checks++;
    if ({mem_we, out_valid, busy, done} !== 4'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl: got %b expected 0000", {mem_we, out_valid, busy, done});
    end
    n_checks++;
    if ({mem_addr, mem_din, out_data} !== '0) begin
      n_errors++;
      $display("FAIL reset_data: got addr=%0h din=%0h byte=%0h expected 0", mem_addr, mem_din, out_data);
    end
    rst = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_basic();
    int t0;
    bit ok;
    clear_logs();
    data = 24'h000010; addr = '0; out_ready = 1'b1; start = 1'b1;
    t0 = cyc;
    repeat (5) step();
    start = 1'b0;
    wait_xfer(ok);
    repeat (3) step();
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL basic_timeout: got busy=%b expected completed transfer", busy); end
    n_checks++;
    if (wr_din_q.size() != 1 || wr_addr_q[0] !== 13'h0 || wr_din_q[0] !== 24'h000010) begin
      n_errors++;
      $display("FAIL basic_write: got n=%0d addr=%0h din=%0h expected 1/0/10", wr_din_q.size(), wr_addr_q[0], wr_din_q[0]);
    end
    n_checks++;
    if (wr_cyc_q[0] != t0 + 1 || first_valid_cyc != t0 + 2 || done_cyc != t0 + 2 + NBYTES) begin
      n_errors++;
      $display("FAIL basic_latency: got we=%0d valid=%0d done=%0d expected %0d/%0d/%0d",
               wr_cyc_q[0] - t0, first_valid_cyc - t0, done_cyc - t0, 1, 2, 2 + NBYTES);
    end
    for (int i = 0; i < NBYTES; i++) begin
      n_checks++;
      if (byte_q.size() != NBYTES || byte_q[i] !== exp_byte(24'h000010, i)) begin
        n_errors++;
        $display("FAIL basic_byte%0d: got %0h expected %0h (n=%0d)", i, byte_q[i], exp_byte(24'h000010, i), byte_q.size());
      end
    end
    n_checks++;
    if (done_cnt != 1) begin n_errors++; $display("FAIL basic_done: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_second();
    int t0;
    bit ok;
    clear_logs();
    out_ready = 1'b1;
    pulse_xfer(24'h000010, 13'h0, t0, ok);
    n_checks++;
    if (!ok || done_cnt != 1 || done_cyc != t0 + 2 + NBYTES) begin
      n_errors++;
      $display("FAIL second_done: got ok=%b n=%0d at %0d expected 1 at %0d", ok, done_cnt, done_cyc - t0, 2 + NBYTES);
    end
    n_checks++;
    if (wr_din_q.size() != 1 || wr_din_q[0] !== 24'h000010 || byte_q.size() != NBYTES ||
        byte_q[0] !== 8'h10 || byte_q[1] !== 8'h00 || byte_q[2] !== 8'h00) begin
      n_errors++;
      $display("FAIL second_data: got writes=%0d bytes=%0d b0=%0h expected 1/3/10", wr_din_q.size(), byte_q.size(), byte_q[0]);
    end
  endtask

  task automatic test_backpressure();
    int t0;
    int n;
    bit ok;
    clear_logs();
    out_ready = 1'b1;
    data = 24'hABCDEF; addr = 13'h1FFF; start = 1'b1;
    t0 = cyc;
    step();
    start = 1'b0;
    n = 0;
    while (byte_q.size() < 1 && n < 20) begin step(); n++; end
    out_ready = 1'b0;
    repeat (3) step();
    out_ready = 1'b1;
    wait_xfer(ok);
    repeat (2) step();
    n_checks++;
    if (!ok || stall_cycles != 3 || stall_viol != 0) begin
      n_errors++;
      $display("FAIL bp_stall: got ok=%b stalls=%0d changes=%0d expected 1/3/0", ok, stall_cycles, stall_viol);
    end
    for (int i = 0; i < NBYTES; i++) begin
      n_checks++;
      if (byte_q[i] !== exp_byte(24'hABCDEF, i)) begin
        n_errors++;
        $display("FAIL bp_byte%0d: got %0h expected %0h", i, byte_q[i], exp_byte(24'hABCDEF, i));
      end
    end
    n_checks++;
    if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 13'h1FFF || done_cyc != t0 + 2 + NBYTES + 3) begin
      n_errors++;
      $display("FAIL bp_addr_done: got addr=%0h done@%0d expected 1fff @%0d", wr_addr_q[0], done_cyc - t0, 5 + 3);
    end
  endtask

  task automatic test_busy_trigger();
    logic [DATA_W-1:0] d1;
    bit ok;
    clear_logs();
    d1 = DATA_W'($urandom);
    out_ready = 1'b1;
    data = d1; addr = 13'h0AA; start = 1'b1;
    step();
    start = 1'b0;
    data  = ~d1;
    addr  = 13'h155;
    repeat (2) step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_xfer(ok);
    repeat (4) step();
    n_checks++;
    if (!ok || done_cnt != 1 || wr_din_q.size() != 1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL busy_trig_count: got ok=%b done=%0d writes=%0d busy=%b expected 1/1/1/0",
               ok, done_cnt, wr_din_q.size(), busy);
    end
    n_checks++;
    if (wr_din_q[0] !== d1 || byte_q.size() != NBYTES || byte_q[0] !== exp_byte(d1, 0) ||
        byte_q[1] !== exp_byte(d1, 1) || byte_q[2] !== exp_byte(d1, 2)) begin
      n_errors++;
      $display("FAIL busy_trig_data: got din=%0h nbytes=%0d expected %0h/3", wr_din_q[0], byte_q.size(), d1);
    end
  endtask

  task automatic test_reset_mid();
    int t0;
    bit ok;
    clear_logs();
    out_ready = 1'b0;
    data = 24'h123456; addr = 13'h0042; start = 1'b1;
    repeat (3) step();
    rst = 1'b1;
    step();
    n_checks++;
    if ({mem_we, out_valid, busy, done} !== 4'b0 || out_data !== '0) begin
      n_errors++;
      $display("FAIL midrst_outputs: got ctrl=%b byte=%0h expected 0", {mem_we, out_valid, busy, done}, out_data);
    end
    step();
    rst = 1'b0;
    repeat (6) step();
    n_checks++;
    if (done_cnt != 0 || wr_din_q.size() != 1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL midrst_abort: got done=%0d writes=%0d busy=%b expected 0/1/0", done_cnt, wr_din_q.size(), busy);
    end
    start = 1'b0;
    step();
    clear_logs();
    out_ready = 1'b1;
    pulse_xfer(24'h00BEEF, 13'h0777, t0, ok);
    n_checks++;
    if (!ok || done_cnt != 1 || wr_addr_q[0] !== 13'h0777 || wr_din_q[0] !== 24'h00BEEF ||
        byte_q.size() != NBYTES || byte_q[0] !== 8'hEF || byte_q[1] !== 8'hBE || byte_q[2] !== 8'h00) begin
      n_errors++;
      $display("FAIL midrst_rerun: got ok=%b done=%0d addr=%0h din=%0h expected 1/1/777/00beef",
               ok, done_cnt, wr_addr_q[0], wr_din_q[0]);
    end
  endtask

  task automatic test_capture();
    logic [DATA_W-1:0] d1;
    logic [ADDR_W-1:0] a1;
    bit ok;
    clear_logs();
    d1 = DATA_W'($urandom);
    a1 = ADDR_W'($urandom);
    out_ready = 1'b1;
    data = d1; addr = a1; start = 1'b1;
    step();
    data = ~d1; addr = ~a1;
    step();
    start = 1'b0;
    wait_xfer(ok);
    repeat (2) step();
    n_checks++;
    if (!ok || wr_addr_q[0] !== a1 || wr_din_q[0] !== d1) begin
      n_errors++;
      $display("FAIL capture_write: got addr=%0h din=%0h expected %0h/%0h", wr_addr_q[0], wr_din_q[0], a1, d1);
    end
    n_checks++;
    if (byte_q.size() != NBYTES || byte_q[0] !== exp_byte(d1, 0) || byte_q[1] !== exp_byte(d1, 1) ||
        byte_q[2] !== exp_byte(d1, 2)) begin
      n_errors++;
      $display("FAIL capture_stream: got n=%0d b0=%0h expected 3/%0h", byte_q.size(), byte_q[0], exp_byte(d1, 0));
    end
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] exp_d[$];
    logic [ADDR_W-1:0] exp_a[$];
    int n;
    clear_logs();
    rand_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      start = 1'b0;
      repeat ($urandom_range(1, 3)) step();
      data = DATA_W'($urandom);
      addr = ADDR_W'($urandom);
      exp_d.push_back(data);
      exp_a.push_back(addr);
      start = 1'b1;
      step();
      data = DATA_W'($urandom);
      addr = ADDR_W'($urandom);
      repeat ($urandom_range(0, 7)) step();
      start = 1'b0;
      n = 0;
      while (done_cnt < k + 1 && n < 300) begin step(); n++; end
      n_checks++;
      if (done_cnt != k + 1) begin
        n_errors++;
        $display("FAIL rand_done%0d: got %0d done pulses expected %0d", k, done_cnt, k + 1);
      end
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    repeat (4) step();
    n_checks++;
    if (wr_din_q.size() != 20 || byte_q.size() != 20 * NBYTES || stall_viol != 0) begin
      n_errors++;
      $display("FAIL rand_totals: got writes=%0d bytes=%0d changes=%0d expected 20/%0d/0",
               wr_din_q.size(), byte_q.size(), stall_viol, 20 * NBYTES);
    end
    for (int k = 0; k < 20; k++) begin
      n_checks++;
      if (wr_din_q[k] !== exp_d[k] || wr_addr_q[k] !== exp_a[k] ||
          byte_q[k*NBYTES] !== exp_byte(exp_d[k], 0) || byte_q[k*NBYTES+1] !== exp_byte(exp_d[k], 1) ||
          byte_q[k*NBYTES+2] !== exp_byte(exp_d[k], 2)) begin
        n_errors++;
        $display("FAIL rand_xfer%0d: got din=%0h addr=%0h expected din=%0h addr=%0h",
                 k, wr_din_q[k], wr_addr_q[k], exp_d[k], exp_a[k]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; data = '0; addr = '0;
    rand_ready = 1'b0;
    prev_stall = 1'b0;
    prev_byte  = '0;
    clear_logs();
    test_reset();
    test_basic();
    test_second();
    test_backpressure();
    test_busy_trigger();
    test_reset_mid();
    test_capture();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got no completion expected finish within 2ms");
    $fatal(1, "watchdog expired");
  end

endmodule
